// File: rtl/mem_map_pkg.sv
// mem_map_pkg: address map, status bit layout and region decode for the data-memory responder
package mem_map_pkg;
  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0000;
  localparam logic [31:0] TXDATA_ADDR = 32'h8000_0004;
  localparam logic [31:0] STATUS_ADDR = 32'h8000_0008;
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_BADADDR   = 3;
  localparam int ST_COUNT_LSB = 8;
  typedef enum logic [2:0] {REG_RAM, REG_CYCLE, REG_TX, REG_STATUS, REG_NONE} region_t;
  // word is the byte address with the byte-lane bits already stripped
  function automatic region_t decode(input logic [31:2] word, input int ram_words);
    return (word - RAM_BASE[31:2] < 30'(ram_words)) ? REG_RAM :
           (word == CYCLE_ADDR[31:2])  ? REG_CYCLE :
           (word == TXDATA_ADDR[31:2]) ? REG_TX :
           (word == STATUS_ADDR[31:2]) ? REG_STATUS : REG_NONE;
  endfunction
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO that drops a push when full unless a pop frees a slot on the same edge
module tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    data_in,
  input  logic          pop,
  output logic [7:0]    data_out,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_pop, do_push;
  assign empty = count == '0;
  assign full = count == CW'(FIFO_DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign data_out = mem[rd_ptr];
  // pointers and occupancy; a simultaneous push and pop on a full FIFO keeps count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage is not reset; stale entries are unreachable once the pointers clear
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= data_in;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: serves core data-port accesses from RAM and a small MMIO page
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  region_t region;
  logic [31:0] ram [DEPTH];
  logic [31:0] cycle, status;
  logic [CW-1:0] count;
  logic ovf, bad, empty, full, push, pop, st_wr;
  logic unused_lanes;
  assign unused_lanes = ^a[1:0];
  assign region = decode(a[31:2], DEPTH);
  assign push = we && region == REG_TX;
  assign st_wr = we && region == REG_STATUS;
  assign pop = out_valid && out_ready;
  assign out_valid = !empty;
  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .data_in(wd[7:0]),
    .pop(pop),
    .data_out(out_data),
    .empty(empty),
    .full(full),
    .count(count)
  );
  // RAM keeps its contents through reset; reset still blocks a write in the same cycle
  always_ff @(posedge clk) begin
    if (!reset && we && region == REG_RAM) ram[a[AW+1:2]] <= wd;
  end
  // free-running cycle counter, a CYCLE write overrides that edge's increment
  always_ff @(posedge clk) begin
    cycle <= reset ? '0 : (we && region == REG_CYCLE) ? wd : cycle + 32'd1;
  end
  // sticky error flags, set by events and cleared by write-1 to STATUS
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      bad <= 1'b0;
    end else begin
      ovf <= (ovf && !(st_wr && wd[ST_OVF])) || (push && full && !pop);
      bad <= (bad && !(st_wr && wd[ST_BADADDR])) || (we && region == REG_NONE);
    end
  end
  // STATUS register image
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVF] = ovf;
    status[ST_BADADDR] = bad;
    status[ST_COUNT_LSB +: 8] = 8'(count);
  end
  // side-effect-free read mux
  always_comb begin
    rd = region == REG_RAM ? ram[a[AW+1:2]] :
         region == REG_CYCLE ? cycle :
         region == REG_STATUS ? status : '0;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and random checks against a queue-based reference model
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam int FD = 8;
  localparam logic [31:0] CYC = 32'h8000_0000;
  localparam logic [31:0] TX = 32'h8000_0004;
  localparam logic [31:0] STAT = 32'h8000_0008;
  logic clk = 1'b0;
  logic reset, we, out_valid, out_ready;
  logic [31:0] a, wd, rd;
  logic [7:0] out_data;
  int checks = 0;
  int passes = 0;
  bit live = 1'b0;
  logic [31:0] last_rd;
  logic [7:0] last_od;
  logic last_ov;
  logic [31:0] mram [int];
  logic [31:0] m_cyc;
  logic [7:0] q [$];
  logic m_ovf, m_bad;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .a(a),
    .wd(wd),
    .rd(rd),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  function automatic bit in_ram(input logic [31:0] addr);
    return (addr & ~32'h3) < 4 * DEPTH;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    logic [31:0] al;
    al = addr & ~32'h3;
    if (in_ram(addr)) return mram[int'(al >> 2)];
    if (al == CYC) return m_cyc;
    if (al == STAT)
      return {16'b0, 8'(q.size()), 4'b0, m_bad, m_ovf, 1'(q.size() == FD), 1'(q.size() == 0)};
    return 32'h0;
  endfunction

  task automatic m_update(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] d, input logic rdy);
    logic [31:0] al;
    al = ad & ~32'h3;
    if (r) begin
      m_cyc = 0;
      q.delete();
      m_ovf = 0;
      m_bad = 0;
      return;
    end
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (w && al == TX) begin
      if (q.size() < FD) q.push_back(d[7:0]);
      else m_ovf = 1;
    end
    m_cyc = (w && al == CYC) ? d : m_cyc + 32'd1;
    if (w && in_ram(ad)) mram[int'(al >> 2)] = d;
    if (w && al == STAT) begin
      if (d[2]) m_ovf = 0;
      if (d[3]) m_bad = 0;
    end
    if (w && !(in_ram(ad) || al == CYC || al == TX || al == STAT)) m_bad = 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    reset = r;
    we = w;
    a = ad;
    wd = d;
    out_ready = rdy;
    #1;
    last_rd = rd;
    last_od = out_data;
    last_ov = out_valid;
    if (!r && live) begin
      if (!in_ram(ad) || mram.exists(int'((ad & ~32'h3) >> 2))) check("rd", rd, m_read(ad));
      check("out_valid", {31'b0, out_valid}, {31'b0, 1'(q.size() != 0)});
      if (q.size() != 0) check("out_data", {24'b0, out_data}, {24'b0, q[0]});
    end
    @(posedge clk);
    m_update(r, w, ad, d, rdy);
    if (r) live = 1'b1;
  endtask

  initial begin
    logic [31:0] ra;
    reset = 1'b1;
    we = 1'b0;
    a = '0;
    wd = '0;
    out_ready = 1'b0;
    repeat (3) step(1, 0, 0, 0, 0);
    step(0, 0, CYC, 0, 0);
    check("cycle_first", last_rd, 32'd0);
    step(0, 0, CYC, 0, 0);
    check("cycle_second", last_rd, 32'd1);
    step(0, 0, STAT, 0, 0);
    check("status_reset", last_rd, 32'h1);
    step(0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    step(0, 1, 4 * DEPTH - 4, 32'h1234_5678, 0);
    step(0, 0, 32'h10, 0, 0);
    check("ram_10", last_rd, 32'hDEAD_BEEF);
    step(0, 0, 32'h11, 0, 0);
    check("ram_11", last_rd, 32'hDEAD_BEEF);
    step(0, 0, 4 * DEPTH - 4, 0, 0);
    check("ram_top", last_rd, 32'h1234_5678);
    step(0, 1, CYC, 32'hFFFF_FFFE, 0);
    step(0, 0, CYC, 0, 0);
    check("cycle_fffe", last_rd, 32'hFFFF_FFFE);
    step(0, 0, CYC, 0, 0);
    check("cycle_ffff", last_rd, 32'hFFFF_FFFF);
    step(0, 0, CYC, 0, 0);
    check("cycle_wrap", last_rd, 32'h0);
    for (int i = 0; i < 9; i++) step(0, 1, TX, 32'h41 + i, 0);
    step(0, 0, STAT, 0, 0);
    check("status_full_ovf", last_rd, 32'h0806);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, STAT, 0, 1);
      check("drain_order", {24'b0, last_od}, 32'h41 + i);
    end
    step(0, 0, STAT, 0, 1);
    check("drained_status", last_rd, 32'h0005);
    check("drained_valid", {31'b0, last_ov}, 32'h0);
    step(0, 1, STAT, 32'h4, 0);
    for (int i = 0; i < 8; i++) step(0, 1, TX, 32'h41 + i, 0);
    step(0, 1, TX, 32'h5A, 1);
    step(0, 0, STAT, 0, 0);
    check("full_push_pop", last_rd, 32'h0802);
    for (int i = 0; i < 8; i++) step(0, 0, STAT, 0, 1);
    check("last_is_5a", {24'b0, last_od}, 32'h5A);
    step(0, 1, TX, 32'h77, 1);
    step(0, 0, STAT, 0, 0);
    check("push_pop_empty", last_rd, 32'h0100);
    step(0, 0, STAT, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 1, TX, 32'h60 + i, 0);
    step(0, 1, 32'h4000_0000, 32'h1, 0);
    step(0, 0, STAT, 0, 0);
    check("status_bad_ovf", last_rd, 32'h080E);
    step(0, 0, 32'h4000_0000, 0, 0);
    check("bad_read_zero", last_rd, 32'h0);
    step(0, 1, STAT, 32'h0C, 0);
    step(0, 0, STAT, 0, 0);
    check("status_cleared", last_rd, 32'h0802);
    for (int i = 0; i < 8; i++) step(0, 0, STAT, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, TX, 32'h30 + i, 0);
    step(0, 0, STAT, 0, 1);
    step(1, 1, CYC, 32'h55, 1);
    step(0, 0, CYC, 0, 1);
    check("reset_cycle", last_rd, 32'h0);
    check("reset_valid", {31'b0, last_ov}, 32'h0);
    step(0, 0, STAT, 0, 0);
    check("reset_status", last_rd, 32'h1);
    step(0, 0, 32'h10, 0, 0);
    check("reset_ram", last_rd, 32'hDEAD_BEEF);
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0, 1: ra = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3);
        2: ra = CYC;
        3: ra = TX;
        4: ra = STAT;
        default: ra = ($urandom_range(0, 1) != 0) ? 32'h8000_000C : 32'h0000_1000 + ($urandom & 32'hFFF);
      endcase
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, ra, $urandom, $urandom_range(0, 2) != 0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
